lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
Load/store stage between the execute stage and the write-back stage. It accepts one instruction at a time from execute over a valid/ready handshake. For loads and stores it performs a single access on a simple request/response memory port, with byte-lane alignment, strobe generation and load sign/zero extension. It then presents the write-back bundle to WBU over a second valid/ready handshake. It is a non-pipelined, single-outstanding, multi-cycle stage.

Parameters:
- ADDR_W, 32, memory address width.
- XLEN, 32, data width. Only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_in_exu  in  1  execute stage holds a valid instruction.
- ready_out_exu  out  1  stage can accept an instruction.
- func3  in  3  RV32 load/store width and sign code.
- mem_ren  in  1  instruction is a load.
- mem_wen  in  1  instruction is a store.
- alu_out  in  32  effective address; also the non-load result.
- wdata  in  32  store data (rs2), unshifted.
- gpr_wen  in  1  pass-through to WBU.
- rd  in  5  pass-through to WBU.
- pc  in  32  pass-through to WBU.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  1 = write, 0 = read.
- mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_req_wdata  out  32  lane-shifted store data.
- mem_req_wstrb  out  4  byte strobes. 0 for reads.
- mem_resp_valid  in  1  response valid. Always accepted; there is no ready.
- mem_resp_rdata  in  32  read word.
- mem_resp_err  in  1  access fault.
- valid_out_wbu  out  1  write-back bundle valid.
- ready_in_wbu  in  1  WBU accepts the bundle.
- wb_data  out  32  extended load result, or latched alu_out for non-loads.
- wb_gpr_wen  out  1  latched gpr_wen, forced to 0 on any fault.
- wb_rd  out  5  latched rd.
- wb_pc  out  32  latched pc.
- wb_misalign  out  1  misaligned access detected.
- wb_access_fault  out  1  mem_resp_err was returned.

Behaviour:
- State machine: IDLE, REQ, RESP, WB. On reset: state = IDLE, every registered output = 0, ready_out_exu = 1.
- ready_out_exu = (state == IDLE). mem_req_valid = (state == REQ). valid_out_wbu = (state == WB).
- IDLE: if valid_in_exu is high, latch all inputs.
  - If (mem_ren | mem_wen) and the access is aligned, go to REQ.
  - Otherwise go to WB.
- Alignment rule:
  - Halfword (func3[1:0] == 01) requires addr[0] == 0.
  - Word (func3[1:0] == 1x) requires addr[1:0] == 0.
  - Byte is always aligned.
  - A misaligned access goes straight to WB with wb_misalign = 1 and issues no bus request.
- If mem_wen and mem_ren are both set, treat the instruction as a store.
- REQ: mem_req_* stay stable while waiting. When mem_req_ready is high, go to RESP.
- RESP: when mem_resp_valid is high, latch rdata and err, then go to WB. The response arrives no earlier than the cycle after the request handshake.
- WB: outputs stay stable. When ready_in_wbu is high, go to IDLE. A new instruction is accepted one cycle later; there is no same-cycle bypass.
- Store lanes (a = addr[1:0]):
  - SB: wstrb = 0001<<a, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<a, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata unchanged.
- Load data: shift rdata right by 8*a, then extend by func3:
  - 000: sign-extend byte.
  - 001: sign-extend half.
  - 010: word.
  - 100: zero-extend byte.
  - 101: zero-extend half.
  - Other codes: word.
- Stores and non-memory instructions: wb_data = alu_out.
- Latency, counted from the accept cycle T:
  - Non-memory instruction: valid_out_wbu at T+1.
  - Memory access with ready=1 and a one-cycle response: request at T+1, response at T+2, valid_out_wbu at T+3.
- mem_resp_valid is ignored outside RESP.
- Reset during REQ or RESP: return to IDLE on the next edge and drop mem_req_valid. A response arriving late after the reset is ignored.

Test Plan:
- ADD result (no mem), alu_out=0x1234, ready_in_wbu=1 -> valid_out_wbu the cycle after accept, wb_data=0x1234, no mem_req_valid pulse.
- SB: addr=0x1003, wdata=0xAABBCCDD, mem_req_ready held 0 for 3 cycles -> mem_req_wstrb=1000, mem_req_wdata=0xDDDDDDDD, mem_req_addr=0x1000, all outputs stable while waiting.
- LB: addr=0x2001, rdata=0x0000F700 -> wb_data=0xFFFFFFF7. LBU at the same address -> 0x000000F7. LHU at addr 0x2002 with rdata 0x8001xxxx -> 0x00008001.
- LW at addr=0x3002 -> wb_misalign=1, wb_gpr_wen=0, no bus request, valid_out_wbu at T+1.
- LW with mem_resp_err=1 -> wb_access_fault=1, wb_gpr_wen=0. Hold ready_in_wbu=0 for 4 cycles -> bundle held, ready_out_exu=0 throughout.
- Assert rst in RESP, then drive a stray mem_resp_valid -> state IDLE, all outputs 0, the stray response is ignored, and the next instruction is processed normally.

Source files
------------

// File: rtl/lsu_stage.sv
// lsu_stage: single-outstanding load/store stage between execute and write-back.
// Accepts one instruction from execute, performs at most one aligned memory
// access with lane steering and load extension, then holds the write-back
// bundle until WBU takes it.
module lsu_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in_exu,
    output logic              ready_out_exu,
    input  logic [2:0]        func3,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   wdata,
    input  logic              gpr_wen,
    input  logic [4:0]        rd,
    input  logic [XLEN-1:0]   pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    input  logic              mem_resp_err,
    output logic              valid_out_wbu,
    input  logic              ready_in_wbu,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_gpr_wen,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_pc,
    output logic              wb_misalign,
    output logic              wb_access_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  lat_func3;
    logic [1:0]  lat_lane;
    logic        lat_load;

    logic            is_mem;
    logic            misalign;
    logic [XLEN-1:0] store_data;
    logic [3:0]      store_strb;
    logic [XLEN-1:0] load_shift;
    logic [XLEN-1:0] load_ext;

    // Decode the incoming instruction: alignment check and store lane steering.
    always_comb begin
        is_mem     = mem_ren | mem_wen;
        misalign   = 1'b0;
        store_data = wdata;
        store_strb = 4'b1111;
        case (func3[1:0])
            2'b00: begin
                store_data = {4{wdata[7:0]}};
                store_strb = 4'(4'b0001 << alu_out[1:0]);
            end
            2'b01: begin
                misalign   = alu_out[0];
                store_data = {2{wdata[15:0]}};
                store_strb = 4'(4'b0011 << alu_out[1:0]);
            end
            default: begin
                misalign   = |alu_out[1:0];
            end
        endcase
    end

    // Right-align the returned word on the accessed lane and extend it.
    always_comb begin
        load_shift = mem_resp_rdata >> {lat_lane, 3'b000};
        case (lat_func3)
            3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_ext = {24'd0, load_shift[7:0]};
            3'b101:  load_ext = {16'd0, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    // Stage state machine with all handshake and bundle outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ready_out_exu   <= 1'b1;
            mem_req_valid   <= 1'b0;
            mem_req_wen     <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_wdata   <= '0;
            mem_req_wstrb   <= '0;
            valid_out_wbu   <= 1'b0;
            wb_data         <= '0;
            wb_gpr_wen      <= 1'b0;
            wb_rd           <= '0;
            wb_pc           <= '0;
            wb_misalign     <= 1'b0;
            wb_access_fault <= 1'b0;
            lat_func3       <= '0;
            lat_lane        <= '0;
            lat_load        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in_exu) begin
                        ready_out_exu   <= 1'b0;
                        wb_data         <= alu_out;
                        wb_rd           <= rd;
                        wb_pc           <= pc;
                        wb_misalign     <= is_mem & misalign;
                        wb_gpr_wen      <= gpr_wen & ~(is_mem & misalign);
                        wb_access_fault <= 1'b0;
                        lat_func3       <= func3;
                        lat_lane        <= alu_out[1:0];
                        lat_load        <= mem_ren & ~mem_wen;
                        if (is_mem && !misalign) begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= mem_wen;
                            mem_req_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
                            mem_req_wdata <= mem_wen ? store_data : '0;
                            mem_req_wstrb <= mem_wen ? store_strb : 4'b0000;
                        end else begin
                            state         <= WB;
                            valid_out_wbu <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= RESP;
                        mem_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        state           <= WB;
                        valid_out_wbu   <= 1'b1;
                        wb_access_fault <= mem_resp_err;
                        if (mem_resp_err) begin
                            wb_gpr_wen <= 1'b0;
                        end
                        if (lat_load) begin
                            wb_data <= load_ext;
                        end
                    end
                end
                WB: begin
                    if (ready_in_wbu) begin
                        state         <= IDLE;
                        valid_out_wbu <= 1'b0;
                        ready_out_exu <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed and randomized checks of lsu_stage against a
// behavioural model of the load/store rules.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_exu;
    logic        ready_out_exu;
    logic [2:0]  func3;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic        gpr_wen;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        valid_out_wbu;
    logic        ready_in_wbu;
    logic [31:0] wb_data;
    logic        wb_gpr_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_pc;
    logic        wb_misalign;
    logic        wb_access_fault;

    int n_checks = 0;
    int n_errors = 0;

    lsu_stage #(.ADDR_W(32), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in_exu    (valid_in_exu),
        .ready_out_exu   (ready_out_exu),
        .func3           (func3),
        .mem_ren         (mem_ren),
        .mem_wen         (mem_wen),
        .alu_out         (alu_out),
        .wdata           (wdata),
        .gpr_wen         (gpr_wen),
        .rd              (rd),
        .pc              (pc),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_wen     (mem_req_wen),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_wstrb   (mem_req_wstrb),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata),
        .mem_resp_err    (mem_resp_err),
        .valid_out_wbu   (valid_out_wbu),
        .ready_in_wbu    (ready_in_wbu),
        .wb_data         (wb_data),
        .wb_gpr_wen      (wb_gpr_wen),
        .wb_rd           (wb_rd),
        .wb_pc           (wb_pc),
        .wb_misalign     (wb_misalign),
        .wb_access_fault (wb_access_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes for a load/store width code.
    function automatic int unsigned acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Load result from the addressed bytes of the returned word.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned u;
        int unsigned b;
        int unsigned h;
        u = rdata >> (8 * (addr % 4));
        b = u % 256;
        h = u % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return 32'(u);
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".ready"},   32'(ready_out_exu), 32'd1);
        check({tag, ".reqv"},    32'(mem_req_valid), 32'd0);
        check({tag, ".reqwen"},  32'(mem_req_wen), 32'd0);
        check({tag, ".reqaddr"}, mem_req_addr, 32'd0);
        check({tag, ".reqwd"},   mem_req_wdata, 32'd0);
        check({tag, ".strb"},    32'(mem_req_wstrb), 32'd0);
        check({tag, ".wbv"},     32'(valid_out_wbu), 32'd0);
        check({tag, ".wbdata"},  wb_data, 32'd0);
        check({tag, ".wbgpr"},   32'(wb_gpr_wen), 32'd0);
        check({tag, ".wbrd"},    32'(wb_rd), 32'd0);
        check({tag, ".wbpc"},    wb_pc, 32'd0);
        check({tag, ".mis"},     32'(wb_misalign), 32'd0);
        check({tag, ".afault"},  32'(wb_access_fault), 32'd0);
    endtask

    // Scramble execute-side inputs so the stage must rely on its latched copies.
    task automatic scramble();
        valid_in_exu = 1'b0;
        func3   = 3'($urandom);
        mem_ren = 1'($urandom);
        mem_wen = 1'($urandom);
        alu_out = $urandom;
        wdata   = $urandom;
        gpr_wen = 1'($urandom);
        rd      = 5'($urandom);
        pc      = $urandom;
    endtask

    // One full instruction through the stage; entered and left on a falling edge.
    task automatic run_instr(input string tag, input logic [2:0] f3, input logic ren,
                             input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                             input logic gw, input logic [4:0] r, input logic [31:0] p,
                             input int req_stall, input int resp_delay,
                             input logic [31:0] rdata, input logic err, input int wb_stall);
        logic        is_mem;
        logic        is_load;
        logic        mis;
        logic [31:0] e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic        e_gpr;
        logic        e_fault;
        is_mem  = ren | wen;
        is_load = ren & ~wen;
        mis     = is_mem && ((addr % acc_size(f3)) != 0);
        if (acc_size(f3) == 1) begin
            e_strb  = 32'(1 << (addr % 4));
            e_wdata = (wd % 256) * 32'h01010101;
        end else if (acc_size(f3) == 2) begin
            e_strb  = 32'(3 << (addr % 4));
            e_wdata = (wd % 65536) * 32'h00010001;
        end else begin
            e_strb  = 32'd15;
            e_wdata = wd;
        end
        e_fault = is_mem && !mis && err;
        e_data  = (is_load && !mis) ? model_load(f3, addr, rdata) : addr;
        e_gpr   = gw && !mis && !e_fault;

        check({tag, ".acc_ready"}, 32'(ready_out_exu), 32'd1);
        valid_in_exu = 1'b1;
        func3 = f3; mem_ren = ren; mem_wen = wen; alu_out = addr;
        wdata = wd; gpr_wen = gw; rd = r; pc = p;
        @(negedge clk);
        scramble();

        if (is_mem && !mis) begin
            for (int i = 0; i <= req_stall; i++) begin
                check({tag, ".reqv"},    32'(mem_req_valid), 32'd1);
                check({tag, ".reqwen"},  32'(mem_req_wen), 32'(wen));
                check({tag, ".reqaddr"}, mem_req_addr, addr & 32'hFFFF_FFFC);
                check({tag, ".strb"},    32'(mem_req_wstrb), wen ? e_strb : 32'd0);
                if (wen) check({tag, ".reqwd"}, mem_req_wdata, e_wdata);
                check({tag, ".req_rdy"}, 32'(ready_out_exu), 32'd0);
                check({tag, ".req_wbv"}, 32'(valid_out_wbu), 32'd0);
                mem_req_ready  = (i == req_stall);
                mem_resp_valid = (i < req_stall) ? 1'($urandom) : 1'b0;
                mem_resp_rdata = $urandom;
                mem_resp_err   = 1'($urandom);
                @(negedge clk);
            end
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            for (int i = 0; i <= resp_delay; i++) begin
                check({tag, ".resp_reqv"}, 32'(mem_req_valid), 32'd0);
                check({tag, ".resp_wbv"},  32'(valid_out_wbu), 32'd0);
                if (i == resp_delay) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = rdata;
                    mem_resp_err   = err;
                end
                @(negedge clk);
            end
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            mem_resp_rdata = $urandom;
        end else begin
            check({tag, ".noreq"}, 32'(mem_req_valid), 32'd0);
        end

        for (int i = 0; i <= wb_stall; i++) begin
            check({tag, ".wbv"},    32'(valid_out_wbu), 32'd1);
            check({tag, ".wbdata"}, wb_data, e_data);
            check({tag, ".wbgpr"},  32'(wb_gpr_wen), 32'(e_gpr));
            check({tag, ".wbrd"},   32'(wb_rd), 32'(r));
            check({tag, ".wbpc"},   wb_pc, p);
            check({tag, ".mis"},    32'(wb_misalign), 32'(mis));
            check({tag, ".afault"}, 32'(wb_access_fault), 32'(e_fault));
            check({tag, ".wb_rdy"}, 32'(ready_out_exu), 32'd0);
            check({tag, ".wb_reqv"}, 32'(mem_req_valid), 32'd0);
            ready_in_wbu = (i == wb_stall);
            @(negedge clk);
        end
        ready_in_wbu = 1'b0;
        check({tag, ".done_wbv"}, 32'(valid_out_wbu), 32'd0);
        check({tag, ".done_rdy"}, 32'(ready_out_exu), 32'd1);
    endtask

    initial begin
        logic [2:0] ld_codes [5];
        logic [2:0] f3;
        logic       ren;
        logic       wen;
        int         kind;
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst = 1'b1;
        valid_in_exu = 1'b0; func3 = '0; mem_ren = 1'b0; mem_wen = 1'b0;
        alu_out = '0; wdata = '0; gpr_wen = 1'b0; rd = '0; pc = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        mem_resp_err = 1'b0; ready_in_wbu = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        run_instr("add",   3'b000, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 5'd3, 32'h100, 0, 0, 32'h0, 1'b0, 0);
        run_instr("sb",    3'b000, 1'b0, 1'b1, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 5'd0, 32'h104, 3, 0, 32'h0, 1'b0, 0);
        run_instr("lb",    3'b000, 1'b1, 1'b0, 32'h0000_2001, 32'h0, 1'b1, 5'd5, 32'h108, 0, 0, 32'h0000_F700, 1'b0, 0);
        run_instr("lbu",   3'b100, 1'b1, 1'b0, 32'h0000_2001, 32'h0, 1'b1, 5'd6, 32'h10C, 0, 0, 32'h0000_F700, 1'b0, 0);
        run_instr("lhu",   3'b101, 1'b1, 1'b0, 32'h0000_2002, 32'h0, 1'b1, 5'd7, 32'h110, 0, 1, 32'h8001_5A5A, 1'b0, 0);
        run_instr("lwmis", 3'b010, 1'b1, 1'b0, 32'h0000_3002, 32'h0, 1'b1, 5'd8, 32'h114, 0, 0, 32'h0, 1'b0, 0);
        run_instr("lwerr", 3'b010, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 1'b1, 5'd9, 32'h118, 0, 0, 32'hDEAD_BEEF, 1'b1, 4);
        run_instr("sh",    3'b001, 1'b1, 1'b1, 32'h0000_4002, 32'h1234_ABCD, 1'b0, 5'd0, 32'h11C, 1, 0, 32'h0, 1'b0, 0);

        // Reset while waiting for a response, then a stray late response.
        valid_in_exu = 1'b1; func3 = 3'b010; mem_ren = 1'b1; mem_wen = 1'b0;
        alu_out = 32'h0000_5000; gpr_wen = 1'b1; rd = 5'd10; pc = 32'h120;
        @(negedge clk);
        scramble();
        check("rstresp.reqv", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rstresp.idle");
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D; mem_resp_err = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        check_idle("rstresp.stray");
        run_instr("postrst", 3'b010, 1'b1, 1'b0, 32'h0000_6004, 32'h0, 1'b1, 5'd11, 32'h124, 0, 0, 32'h1357_9BDF, 1'b0, 0);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 2));
            ren = 1'b0; wen = 1'b0; f3 = 3'($urandom);
            if (kind == 1) begin
                ren = 1'b1;
                f3 = ld_codes[$urandom_range(0, 4)];
            end else if (kind == 2) begin
                wen = 1'b1;
                ren = 1'($urandom);
                f3 = 3'($urandom_range(0, 2));
            end
            run_instr("rand", f3, ren, wen, $urandom, $urandom, 1'($urandom), 5'($urandom),
                      $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      $urandom, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
